sar_phase_voter: RTL and testbench
==================================

# sar_phase_voter

Decision front-end for the 10-bit SAR delay-line controller in the FMDLL.
- Takes raw lead/lag pulses from the bang-bang phase detector and integrates them over a fixed window, filtering PD chatter.
- Issues one registered COMP decision plus a one-cycle step strobe per SAR bit, with a settling gap after each step.
- After the last bit, keeps voting in tracking mode and reports lock when phase stays balanced.

## Interface
- WIN_LOG2, 3: vote window = 2^WIN_LOG2 clk4 cycles
- SETTLE_CYC, 4: cycles after each step during which lead/lag are ignored (delay-line settling); must be ≥1
- NBITS, 10: SAR bits, i.e. steps per acquisition
- TOL, 1: in TRACK, a window is balanced when |score| ≤ TOL
- LOCK_CNT, 4: consecutive balanced windows required to assert locked
- clk4  in  1  block clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- lead  in  1  PD lead indication, synchronous to clk4
- lag  in  1  PD lag indication, synchronous to clk4
- start  in  1  begin an acquisition (single-cycle or level; sampled only in IDLE and TRACK)
- COMP  out  1  registered decision: 1 = lead, 0 = lag; held between decisions
- step  out  1  one-cycle strobe; the SAR consumes COMP while step = 1
- busy  out  1  high from ACCUM of bit 1 until TRACK is entered
- done  out  1  level: all NBITS decisions issued
- locked  out  1  level: tracking lock achieved

## Operation
- Reset values: COMP=1, step=0, busy=0, done=0, locked=0, score=0, window counter=0, bit counter=NBITS, balanced counter=0, state=IDLE.
- Score: signed, WIN_LOG2+2 bits (range ±2^WIN_LOG2, no overflow possible). Per ACCUM cycle:
  - lead=1 and lag=0: +1
  - lag=1 and lead=0: −1
  - both high or both low: unchanged
- IDLE: start=1 → ACCUM. Clears score and window counter, loads bit counter=NBITS, sets busy=1.
- ACCUM: runs exactly 2^WIN_LOG2 cycles, then → DECIDE.
- DECIDE (1 cycle):
  - COMP ← (score ≥ 0). A tie resolves to 1.
  - step=1; bit counter decrements; score cleared.
  - Bit counter now 0 → TRACK, with busy←0 and done←1. Otherwise → SETTLE.
- SETTLE: SETTLE_CYC cycles, lead/lag ignored, then → ACCUM.
- TRACK: windows repeat back-to-back with no SETTLE. step stays 0 and COMP holds its last acquisition value.
  - At the end of each window: |score| ≤ TOL → balanced counter +1, saturating at LOCK_CNT; otherwise balanced counter=0 and locked=0.
  - locked=1 once the balanced counter reaches LOCK_CNT.
- start=1 in TRACK: restart acquisition exactly as from IDLE, with done=0 and locked=0 set on the same edge.
- start in ACCUM, DECIDE or SETTLE: ignored.
- rst_n low at any time: immediate return to the reset values, including mid-window and mid-step. A step pulse in flight is cut.

## Timing
- Let start be sampled at posedge k (defaults):
  - ACCUM: k+1..k+8
  - DECIDE: k+9 (step=1, new COMP visible after edge k+9)
  - SETTLE: k+10..k+13
- Per-bit period = 2^WIN_LOG2 + 1 + SETTLE_CYC = 13 cycles.
- The n-th step is asserted at k+9+13·(n−1); the 10th is at k+126.
- done=1 and busy=0 from edge k+126; first TRACK window is k+127..k+134.
- COMP and step change on the same edge. The SAR samples on negedge clk4, mid-cycle, so it sees a stable pair.
- Earliest locked with defaults: end of the 4th balanced TRACK window, k+126+4·8 = k+158.

## Test plan
- Reset/idle: rst_n=0, then release with lead=lag=0 for 20 cycles → COMP=1; step, busy, done and locked stay 0.
- All-lead acquisition: start at k, lead=1 constant → exactly 10 step pulses at k+9, k+22, …, k+126, each with COMP=1; done=1 from k+126.
- Majority and tie: window with 5 lag / 3 lead → COMP=0. Next window with 4 lead / 4 lag (or lead=lag=1 throughout) → COMP=1.
- Settle masking: lag=1 only during SETTLE cycles, 0 elsewhere → every decision is a tie → COMP=1 on every step.
- Lock and loss: after done, alternate lead/lag each cycle (score 0) → locked=1 at k+158. Then one window of all lag (score −8) → locked=0 at that window's end.
- Mid-operation reset and restart: rst_n low at k+50 → all outputs return to reset values immediately. start during SETTLE → ignored. start in TRACK → done=0, locked=0, first new step 9 cycles later.

Source files
------------

// File: rtl/sar_phase_voter_if.sv
// Phase-detector inputs and SAR decision outputs of the phase voter.
// COMP is meaningful to the SAR only in the cycle where step=1; there is no back-pressure.
interface sar_phase_voter_if;
  logic lead;
  logic lag;
  logic start;
  logic COMP;
  logic step;
  logic busy;
  logic done;
  logic locked;

  modport master (
    output lead, lag, start,
    input  COMP, step, busy, done, locked
  );

  modport slave (
    input  lead, lag, start,
    output COMP, step, busy, done, locked
  );
endinterface

// File: rtl/sar_phase_voter.sv
// Integrates bang-bang PD lead/lag over fixed windows and issues one COMP decision
// per SAR bit, then keeps voting in tracking mode to report lock.
module sar_phase_voter #(
  parameter int WIN_LOG2   = 3,
  parameter int SETTLE_CYC = 4,
  parameter int NBITS      = 10,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4
) (
  input  logic               clk4,
  input  logic               rst_n,
  sar_phase_voter_if.slave   bus,
  output logic [2:0]         dbg_state
);

  localparam int SW    = WIN_LOG2 + 2;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int BIT_W = $clog2(NBITS + 1);
  localparam int BAL_W = $clog2(LOCK_CNT + 1);

  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
  localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [BIT_W-1:0]    BIT_INIT = BIT_W'(NBITS);
  localparam logic [BAL_W-1:0]    BAL_SAT  = BAL_W'(LOCK_CNT);
  localparam logic signed [SW-1:0] TOL_P   = SW'(TOL);
  localparam logic signed [SW-1:0] TOL_N   = SW'(-TOL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_DECIDE = 3'd2,
    S_SETTLE = 3'd3,
    S_TRACK  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic signed [SW-1:0]   score_q, score_d;
  logic [WIN_LOG2-1:0]    win_q, win_d;
  logic [SET_W-1:0]       set_q, set_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [BAL_W-1:0]       bal_q, bal_d;
  logic                   comp_q, comp_d;
  logic                   step_q, step_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   locked_q, locked_d;

  logic signed [SW-1:0]   delta;
  logic signed [SW-1:0]   score_acc;
  logic                   balanced;
  logic [BAL_W-1:0]       bal_inc;

  // Disagreeing PD outputs vote; agreeing ones (both or neither) carry no information.
  assign delta     = (bus.lead && !bus.lag) ? SW'(1) :
                     (bus.lag && !bus.lead) ? SW'(-1) : SW'(0);
  assign score_acc = score_q + delta;
  assign balanced  = (score_acc <= TOL_P) && (score_acc >= TOL_N);
  assign bal_inc   = (bal_q == BAL_SAT) ? bal_q : bal_q + 1'b1;

  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      win_q    <= '0;
      set_q    <= '0;
      bit_q    <= BIT_INIT;
      bal_q    <= '0;
      comp_q   <= 1'b1;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      win_q    <= win_d;
      set_q    <= set_d;
      bit_q    <= bit_d;
      bal_q    <= bal_d;
      comp_q   <= comp_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    win_d    = win_q;
    set_d    = set_q;
    bit_d    = bit_q;
    bal_d    = bal_q;
    comp_d   = comp_q;
    step_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    locked_d = locked_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
          score_d = '0;
          win_d   = '0;
          bit_d   = BIT_INIT;
          busy_d  = 1'b1;
        end
      end
      S_ACCUM: begin
        score_d = score_acc;
        win_d   = win_q + 1'b1;
        if (win_q == WIN_LAST) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        comp_d  = ~score_q[SW-1];
        step_d  = 1'b1;
        bit_d   = bit_q - 1'b1;
        score_d = '0;
        set_d   = '0;
        if (bit_q == BIT_W'(1)) begin
          state_d = S_TRACK;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        set_d = set_q + 1'b1;
        if (set_q == SET_LAST) state_d = S_ACCUM;
      end
      S_TRACK: begin
        if (bus.start) begin
          state_d  = S_ACCUM;
          score_d  = '0;
          win_d    = '0;
          bit_d    = BIT_INIT;
          bal_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          locked_d = 1'b0;
        end else begin
          score_d = score_acc;
          win_d   = win_q + 1'b1;
          // Window boundary: judge the window including this cycle's vote, then start fresh.
          if (win_q == WIN_LAST) begin
            score_d = '0;
            if (balanced) begin
              bal_d    = bal_inc;
              locked_d = (bal_inc == BAL_SAT);
            end else begin
              bal_d    = '0;
              locked_d = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.COMP   = comp_q;
  assign bus.step   = step_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.locked = locked_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sar_phase_voter.sv
// Bench for sar_phase_voter: a phase-arithmetic model compared every cycle, plus
// hand-computed step times and output values relative to each start edge.
module tb_sar_phase_voter;

  localparam int WIN  = 8;
  localparam int PER  = 13;
  localparam int ACQ  = 126;
  localparam int TOL  = 1;
  localparam int LOCK = 4;

  localparam int M_IDLE = 0;
  localparam int M_LEAD = 1;
  localparam int M_MAJ  = 2;
  localparam int M_SETL = 3;

  localparam int SG_COMP = 0;
  localparam int SG_STEP = 1;
  localparam int SG_BUSY = 2;
  localparam int SG_DONE = 3;
  localparam int SG_LOCK = 4;

  // ---------------- clock / reset ----------------
  logic       clk4  = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         cyc   = 0;

  always #5 clk4 = ~clk4;
  always @(posedge clk4) cyc <= cyc + 1;

  sar_phase_voter_if bus ();

  sar_phase_voter #(
    .WIN_LOG2  (3),
    .SETTLE_CYC(4),
    .NBITS     (10),
    .TOL       (1),
    .LOCK_CNT  (4)
  ) dut (
    .clk4     (clk4),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int vectors    = 0;
  int miscompares = 0;
  int kref       = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int   rel;
    int   sig;
    logic val;
  } lit_t;
  lit_t lit_q[$];
  int   lit_hits = 0;

  // ---------------- behavioural model ----------------
  // m_t counts edges since the start edge: 1..ACQ is acquisition, beyond is tracking.
  int   m_t = -1;
  int   m_sum = 0;
  int   m_bal = 0;
  int   m_d, m_o;
  logic m_comp = 1'b1, m_step = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_locked = 1'b0;

  always @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      m_t = -1; m_sum = 0; m_bal = 0;
      m_comp = 1'b1; m_step = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_locked = 1'b0;
    end else begin
      m_step = 1'b0;
      m_d = (bus.lead && !bus.lag) ? 1 : ((bus.lag && !bus.lead) ? -1 : 0);
      if (bus.start && (m_t < 0 || m_t > ACQ)) begin
        m_t = 0; m_sum = 0; m_bal = 0;
        m_busy = 1'b1; m_done = 1'b0; m_locked = 1'b0;
      end else if (m_t >= 0) begin
        m_t = m_t + 1;
        if (m_t <= ACQ) begin
          m_o = (m_t - 1) % PER;
          if (m_o < WIN) begin
            m_sum = m_sum + m_d;
          end else if (m_o == WIN) begin
            m_comp = (m_sum >= 0);
            m_step = 1'b1;
            m_sum  = 0;
            if (m_t == ACQ) begin
              m_busy = 1'b0;
              m_done = 1'b1;
            end
          end
        end else begin
          m_sum = m_sum + m_d;
          if ((m_t - ACQ) % WIN == 0) begin
            if (m_sum <= TOL && m_sum >= -TOL) begin
              m_bal = (m_bal < LOCK) ? m_bal + 1 : LOCK;
              m_locked = (m_bal == LOCK);
            end else begin
              m_bal = 0;
              m_locked = 1'b0;
            end
            m_sum = 0;
          end
        end
      end
    end
  end

  // ---------------- compare helpers ----------------
  task automatic cmp(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d rel=%0d got=%b want=%b state=%0d",
               name, cyc, cyc - kref, act, exp, dbg_state);
    end
  endtask

  task automatic cmpi(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic sig_val(input int s);
    case (s)
      SG_COMP: return bus.COMP;
      SG_STEP: return bus.step;
      SG_BUSY: return bus.busy;
      SG_DONE: return bus.done;
      default: return bus.locked;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      SG_COMP: return "lit_COMP";
      SG_STEP: return "lit_step";
      SG_BUSY: return "lit_busy";
      SG_DONE: return "lit_done";
      default: return "lit_locked";
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk4) begin
    #1;
    cmp("COMP",   bus.COMP,   m_comp);
    cmp("step",   bus.step,   m_step);
    cmp("busy",   bus.busy,   m_busy);
    cmp("done",   bus.done,   m_done);
    cmp("locked", bus.locked, m_locked);
    if (bus.step === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL step_unexpected cyc=%0d rel=%0d got=1 want=0", cyc, cyc - kref);
      end else begin
        cmpi("step_time", cyc - kref, int'(exp_q.pop_front()));
      end
    end
    foreach (lit_q[i]) begin
      if (lit_q[i].rel == cyc - kref) begin
        lit_hits++;
        cmp(sig_name(lit_q[i].sig), sig_val(lit_q[i].sig), lit_q[i].val);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Returns {start, lead, lag} for the edge at offset r from the start edge.
  function automatic logic [2:0] pat(input int m, input int r);
    logic alt_lead;
    alt_lead = (r % 2 == 1);
    case (m)
      M_LEAD: begin
        if (r == 0)   return 3'b110;
        if (r <= 126) return 3'b010;
        if (r <= 158) return {1'b0, alt_lead, ~alt_lead};
        if (r <= 166) return 3'b001;
        return 3'b000;
      end
      M_MAJ: begin
        if (r == 0)             return 3'b100;
        if (r >= 1 && r <= 5)   return 3'b001;
        if (r >= 6 && r <= 8)   return 3'b010;
        if (r >= 14 && r <= 21) return {1'b0, alt_lead, ~alt_lead};
        if (r >= 27 && r <= 34) return 3'b011;
        if (r >= 40 && r <= 47) return 3'b001;
        return 3'b000;
      end
      M_SETL: begin
        if (r == 0)  return 3'b100;
        if (r == 11) return 3'b101;
        if (r >= 1 && r <= 126) return {2'b00, logic'(((r - 1) % PER) >= WIN + 1)};
        if (r >= 127 && r <= 158) return {1'b0, alt_lead, ~alt_lead};
        if (r == 160) return 3'b100;
        return 3'b000;
      end
      default: return 3'b000;
    endcase
  endfunction

  task automatic add_lit(input int r, input int s, input logic v);
    lit_t e;
    e.rel = r;
    e.sig = s;
    e.val = v;
    lit_q.push_back(e);
  endtask

  task automatic run_test(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk4);
      if (i == 0) kref = cyc + 1;
      {bus.start, bus.lead, bus.lag} = pat(m, cyc + 1 - kref);
    end
  endtask

  task automatic end_test(input string name);
    @(negedge clk4);
    #2;
    cmpi({name, "_steps_left"}, exp_q.size(), 0);
    cmpi({name, "_lits_hit"}, lit_hits, lit_q.size());
    exp_q.delete();
    lit_q.delete();
    lit_hits = 0;
  endtask

  initial begin
    bus.lead  = 1'b0;
    bus.lag   = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk4);
    rst_n = 1'b1;

    // Reset / idle: no start, PD quiet.
    for (int s = 0; s < 5; s++) add_lit(19, s, (s == SG_COMP));
    run_test(M_IDLE, 20);
    end_test("idle");

    // All-lead acquisition, then lock on alternating votes and loss on an all-lag window.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(16'(9 + 13 * i));
      add_lit(9 + 13 * i, SG_COMP, 1'b1);
    end
    add_lit(0,   SG_BUSY, 1'b1);
    add_lit(125, SG_DONE, 1'b0);
    add_lit(125, SG_BUSY, 1'b1);
    add_lit(126, SG_DONE, 1'b1);
    add_lit(126, SG_BUSY, 1'b0);
    add_lit(157, SG_LOCK, 1'b0);
    add_lit(158, SG_LOCK, 1'b1);
    add_lit(165, SG_LOCK, 1'b1);
    add_lit(166, SG_LOCK, 1'b0);
    run_test(M_LEAD, 171);
    end_test("lead");

    // Restart from TRACK; majority, tie by alternation, tie by both-high, all lag.
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(16'd9);
    exp_q.push_back(16'd22);
    exp_q.push_back(16'd35);
    exp_q.push_back(16'd48);
    add_lit(-1, SG_DONE, 1'b1);
    add_lit(0,  SG_DONE, 1'b0);
    add_lit(0,  SG_BUSY, 1'b1);
    add_lit(9,  SG_COMP, 1'b0);
    add_lit(22, SG_COMP, 1'b1);
    add_lit(35, SG_COMP, 1'b1);
    add_lit(48, SG_COMP, 1'b0);
    add_lit(48, SG_STEP, 1'b1);
    run_test(M_MAJ, 49);
    // Reset lands while the step of the fourth bit is high.
    @(negedge clk4);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("rst_COMP",   bus.COMP,   1'b1);
    cmp("rst_step",   bus.step,   1'b0);
    cmp("rst_busy",   bus.busy,   1'b0);
    cmp("rst_done",   bus.done,   1'b0);
    cmp("rst_locked", bus.locked, 1'b0);
    cmpi("maj_steps_left", exp_q.size(), 0);
    cmpi("maj_lits_hit", lit_hits, lit_q.size());
    exp_q.delete();
    lit_q.delete();
    lit_hits = 0;
    repeat (3) @(negedge clk4);
    rst_n = 1'b1;

    // Lag only during SETTLE (plus an ignored start), then lock and restart from TRACK.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(16'(9 + 13 * i));
      add_lit(9 + 13 * i, SG_COMP, 1'b1);
    end
    exp_q.push_back(16'd169);
    add_lit(157, SG_LOCK, 1'b0);
    add_lit(158, SG_LOCK, 1'b1);
    add_lit(159, SG_LOCK, 1'b1);
    add_lit(160, SG_LOCK, 1'b0);
    add_lit(160, SG_DONE, 1'b0);
    add_lit(160, SG_BUSY, 1'b1);
    add_lit(169, SG_STEP, 1'b1);
    run_test(M_SETL, 176);
    end_test("settle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
